// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: FSM state encoding and default width.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_count_timer.sv
// Loadable down-counting timer with valid/ready load port, one-cycle terminal-count
// pulse and optional auto-reload for periodic ticks.
module down_count_timer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             tc
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] start_cnt;
    logic             tc_d;

    assign load_ready = (state_q != RUN);
    assign count_out  = count_q;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            busy     <= 1'b0;
            tc       <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy     <= (state_d == RUN);
            tc       <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        // Restarting from DONE counts from the stored reload value, not the zeroed count.
        start_cnt = (state_q == DONE) ? reload_q : count_q;

        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else if (load_valid && load_ready) begin
            state_d  = ARMED;
            count_d  = load_data;
            reload_d = load_data;
        end else if (start && (state_q == ARMED || state_q == DONE)) begin
            if (start_cnt == '0) begin
                state_d = DONE;
                count_d = '0;
                tc_d    = 1'b1;
            end else begin
                state_d = RUN;
                count_d = start_cnt;
            end
        end else if (state_q == RUN && en) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                tc_d = 1'b1;
                if (AUTO_RELOAD && reload_q != '0) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_down_count_timer.sv
// Directed bench for down_count_timer: one-shot and auto-reload instances checked
// every cycle against a behavioural model, plus hand-computed sequence checks.
module tb_down_count_timer;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       load_valid, start, en, abort;
    logic [3:0] load_data;

    logic       a_ready, a_busy, a_tc;
    logic [3:0] a_count;
    logic       r_ready, r_busy, r_tc;
    logic [3:0] r_count;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    down_count_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_oneshot (
        .clk(clk), .clear_n(clear_n), .load_valid(load_valid), .load_ready(a_ready),
        .load_data(load_data), .start(start), .en(en), .abort(abort),
        .count_out(a_count), .busy(a_busy), .tc(a_tc)
    );

    down_count_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_reload (
        .clk(clk), .clear_n(clear_n), .load_valid(load_valid), .load_ready(r_ready),
        .load_data(load_data), .start(start), .en(en), .abort(abort),
        .count_out(r_count), .busy(r_busy), .tc(r_tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 armed, 2 running, 3 done.
    typedef struct {
        int cnt;
        int rld;
        int ph;
        bit tc;
    } mdl_t;

    mdl_t ma, mr;

    function automatic mdl_t mstep(mdl_t m, bit ar);
        mdl_t n;
        int   c;
        n    = m;
        n.tc = 1'b0;
        if (abort) begin
            n.ph  = 0;
            n.cnt = 0;
        end else if (load_valid && m.ph != 2) begin
            n.cnt = int'(load_data);
            n.rld = int'(load_data);
            n.ph  = 1;
        end else if (start && (m.ph == 1 || m.ph == 3)) begin
            c = (m.ph == 3) ? m.rld : m.cnt;
            if (c == 0) begin
                n.ph  = 3;
                n.cnt = 0;
                n.tc  = 1'b1;
            end else begin
                n.ph  = 2;
                n.cnt = c;
            end
        end else if (m.ph == 2 && en) begin
            n.cnt = m.cnt - 1;
            if (n.cnt == 0) begin
                n.tc = 1'b1;
                if (ar) n.cnt = m.rld;
                else    n.ph  = 3;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            ma = '{0, 0, 0, 1'b0};
            mr = '{0, 0, 0, 1'b0};
        end else begin
            ma = mstep(ma, 1'b0);
            mr = mstep(mr, 1'b1);
        end
    end

    always @(negedge clk) begin
        if (chk_on && clear_n) begin
            check("oneshot_count", a_count, ma.cnt);
            check("oneshot_busy",  a_busy,  ma.ph == 2);
            check("oneshot_tc",    a_tc,    ma.tc);
            check("oneshot_ready", a_ready, ma.ph != 2);
            check("reload_count",  r_count, mr.cnt);
            check("reload_busy",   r_busy,  mr.ph == 2);
            check("reload_tc",     r_tc,    mr.tc);
            check("reload_ready",  r_ready, mr.ph != 2);
        end
    end

    // Drive inputs for one clock edge, return just after that edge.
    task automatic cyc(input bit lv, input int ld, input bit st, input bit e, input bit ab);
        @(negedge clk);
        #1;
        load_valid = lv;
        load_data  = 4'(ld);
        start      = st;
        en         = e;
        abort      = ab;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_cnt[5];
        int exp_r[6];
        int en_pat[5];
        int npulse;

        clear_n = 1'b0; load_valid = 1'b0; load_data = '0;
        start = 1'b0; en = 1'b0; abort = 1'b0;
        #1;
        check("reset_count", a_count, 0);
        check("reset_busy",  a_busy,  0);
        check("reset_tc",    a_tc,    0);
        check("reset_ready", a_ready, 1);
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        chk_on  = 1'b1;

        // Load 5 and count down; a load attempt while running is ignored.
        exp_cnt = '{4, 3, 2, 1, 0};
        cyc(1, 5, 0, 0, 0);
        check("t1_load", a_count, 5);
        cyc(0, 0, 1, 0, 0);
        check("t1_start_cnt",  a_count, 5);
        check("t1_start_busy", a_busy,  1);
        for (int i = 0; i < 5; i++) begin
            cyc(i == 1, 9, 0, 1, 0);
            check("t1_cnt",  a_count, exp_cnt[i]);
            check("t1_tc",   a_tc,    i == 4);
            check("t1_busy", a_busy,  i < 4);
        end
        check("t1_ready", a_ready, 1);
        cyc(0, 0, 0, 1, 0);
        check("t1_tc_gone", a_tc, 0);
        cyc(0, 0, 1, 0, 0);
        check("t1_restart", a_count, 5);

        // Load 3 with en toggling.
        cyc(0, 0, 0, 0, 1);
        exp_cnt = '{2, 2, 1, 1, 0};
        en_pat  = '{1, 0, 1, 0, 1};
        cyc(1, 3, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, en_pat[i] != 0, 0);
            check("t2_cnt", a_count, exp_cnt[i]);
            check("t2_tc",  a_tc,    i == 4);
        end

        // Auto-reload with 2: periodic tc, busy held.
        cyc(0, 0, 0, 0, 1);
        exp_r  = '{1, 2, 1, 2, 1, 2};
        npulse = 0;
        cyc(1, 2, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("t3_start", r_count, 2);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1, 0);
            check("t3_cnt",  r_count, exp_r[i]);
            check("t3_busy", r_busy,  1);
            if (r_tc) npulse++;
        end
        check("t3_pulses", npulse, 3);

        // Zero load, then load+start collision in ARMED.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("t4_tc",    a_tc,    1);
        check("t4_busy",  a_busy,  0);
        check("t4_rtc",   r_tc,    1);
        check("t4_rbusy", r_busy,  0);
        cyc(0, 0, 0, 1, 0);
        check("t4_tc_off", a_tc, 0);
        cyc(1, 8, 1, 0, 0);
        check("t4_collide_cnt",  a_count, 8);
        check("t4_collide_busy", a_busy,  0);

        // Abort mid-count, start in IDLE ignored, reload new value.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 7, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        check("t5_abort_cnt",  a_count, 0);
        check("t5_abort_busy", a_busy,  0);
        check("t5_abort_tc",   a_tc,    0);
        cyc(0, 0, 1, 1, 0);
        check("t5_idle_start", a_busy, 0);
        cyc(1, 4, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        check("t5_from4", a_count, 4);
        cyc(0, 0, 0, 1, 0);
        check("t5_dec", a_count, 3);

        // Asynchronous reset mid-count.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 6, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("t6_pre", a_count, 6);
        #2;
        clear_n = 1'b0;
        #1;
        check("t6_async_cnt",  a_count, 0);
        check("t6_async_busy", a_busy,  0);
        check("t6_async_rcnt", r_count, 0);
        @(negedge clk);
        clear_n = 1'b1;
        cyc(0, 0, 1, 1, 0);
        check("t6_start_ign", a_busy, 0);
        cyc(0, 0, 1, 1, 0);
        check("t6_start_ign2", a_count, 0);
        cyc(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
